comm_gather: RTL and testbench
==============================

Name: comm_gather

Overview:
- Reverse-direction companion to the pipelined commutator. Collects single-cycle data pulses from nSRC endpoint channels into one valid/ready output stream.
- Each output word is tagged with the index of the channel that produced it.
- Each source has a one-entry holding register. Sources are served by a registered round-robin arbiter, so no source starves and simultaneous pulses are not lost unless a source overruns its own slot.
- Sits between the endpoint array and the input side of the commutator; out_addr plays the role of the commutator's return address.

Parameters:
- nSRC, 13, number of endpoint source channels (>=2)
- wD, 25, data width
- wA (localparam), $clog2(nSRC), source index width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_in  input  nSRC  per-source one-cycle valid pulse; no backpressure on the source side
- data_in  input  nSRC*wD  per-source data; channel k occupies bits [(k+1)*wD-1 : k*wD]
- src_busy  output  nSRC  bit k high while slot k holds an ungranted word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accept
- out_data  output  wD  gathered data
- out_addr  output  wA  source index of out_data
- ovf  output  nSRC  sticky per-source overrun flag
- ovf_clr  input  1  one-cycle pulse; clears all ovf bits

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: src_busy=0, out_valid=0, out_data=0, out_addr=0, ovf=0, round-robin pointer rr_ptr=0. All holding slots are empty with data 0.
- Reset mid-operation: all pending and output words are discarded without being emitted.
- Slot capture:
  - req_in[k] at edge t loads data_in[k] into slot k; src_busy[k]=1 from t+1.
  - Capture happens when the slot is empty, or when the slot is granted in the same cycle. A freed slot refills with no overflow.
- Overrun:
  - req_in[k] while slot k is busy and not granted that cycle: new data is dropped, the old word is kept, and ovf[k] is set at the next edge.
  - ovf_clr takes priority over a same-cycle set.
- Output register load:
  - "load" = (!out_valid) || (out_valid && out_ready).
  - On load, if any slot is busy, grant the first busy slot k scanning from rr_ptr upward with wrap-around modulo nSRC.
  - The grant drives out_data <= slot k, out_addr <= k, out_valid <= 1, clears src_busy[k], and sets rr_ptr <= (k+1) mod nSRC. The wrap uses an explicit compare, since nSRC is not necessarily a power of two.
  - On load with no busy slot: out_valid <= 0, and out_data/out_addr hold their values.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data and out_addr are stable.
  - A transfer occurs on any edge with out_valid & out_ready.
  - Back-to-back transfers run at 1 word/cycle while slots are pending.
- Latency: req_in at edge t → out_valid at edge t+2 when the output is idle (slot at t+1, output register at t+2).
- Simultaneous requests in one cycle on several sources: all are captured and emitted in round-robin order, one per accepted cycle.
- A same-cycle req_in[k] and grant of slot k: the old word goes out and the new word occupies the slot.
- Data on data_in[k] is ignored when req_in[k]=0.
- Throughput bound: each source may pulse at most once per nSRC accepted output cycles without overrun under full contention.

Test Plan:
1. Single pulse: reset, out_ready=1; req_in[5]=1 with data 0x0ABCDEF for one cycle → two edges later out_valid=1, out_data=0x0ABCDEF, out_addr=5 for exactly one cycle; src_busy[5] high for one cycle only.
2. Round-robin fairness: all 13 sources pulse together with data 0x100+k, out_ready=1 → 13 consecutive words with out_addr=0,1,…,12. Then re-pulse sources 3 and 11 → out_addr 3 then 11, since rr_ptr=0 after the wrap.
3. Backpressure: pulse sources 2 and 7, hold out_ready=0 for 10 cycles → out_valid=1, out_addr=2, data stable throughout. Release → addr 2 and addr 7 on consecutive cycles.
4. Overrun: out_ready=0 and slot 4 busy; second req_in[4] with new data → ovf[4]=1 and the first data is emitted later. Then ovf_clr → ovf=0. ovf_clr in the same cycle as a set → ovf[4]=0.
5. Refill on grant: source 9 pulses on the exact cycle its slot is granted → no ovf; both words are emitted with addr 9, in order.
6. Reset mid-stream: 6 slots busy and out_valid=1, assert reset for one cycle → next cycle out_valid=0, src_busy=0, ovf=0; the next grant starts from source 0.

Source files
------------

// File: rtl/comm_gather.sv
// ============================================================================
// Module   : comm_gather
// Purpose  : Gathers single-cycle pulses from nSRC sources into one tagged
//            valid/ready stream via per-source slots and round-robin grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comm_gather #(
  parameter  int nSRC = 13,
  parameter  int wD   = 25,
  localparam int wA   = $clog2(nSRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [nSRC-1:0]    req_in,
  input  logic [nSRC*wD-1:0] data_in,
  output logic [nSRC-1:0]    src_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [wD-1:0]      out_data,
  output logic [wA-1:0]      out_addr,
  output logic [nSRC-1:0]    ovf,
  input  logic               ovf_clr
);

  localparam logic [wA-1:0] c_LAST_IDX = wA'(nSRC - 1);
  localparam logic [wA:0]   c_NSRC     = (wA + 1)'(nSRC);

  logic [wD-1:0]   r_slot [nSRC];
  logic [nSRC-1:0] r_busy;
  logic [nSRC-1:0] r_ovf;
  logic [wA-1:0]   r_rr_ptr;
  logic            r_out_valid;
  logic [wD-1:0]   r_out_data;
  logic [wA-1:0]   r_out_addr;

  logic            w_load;
  logic            w_gnt_any;
  logic [wA-1:0]   w_gnt_idx;
  logic [wA:0]     w_scan;
  logic [nSRC-1:0] w_gnt_vec;
  logic [nSRC-1:0] w_cap_vec;

  assign w_load = !r_out_valid || out_ready;

  // Descending offset scan: the busy slot closest above rr_ptr is assigned last and wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = nSRC - 1; i >= 0; i--) begin
      w_scan = {1'b0, r_rr_ptr} + (wA + 1)'(i);
      if (w_scan >= c_NSRC)
        w_scan = w_scan - c_NSRC;
      if (r_busy[w_scan[wA-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan[wA-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_vec = '0;
    w_cap_vec = '0;
    for (int k = 0; k < nSRC; k++) begin
      w_gnt_vec[k] = w_load && w_gnt_any && (w_gnt_idx == wA'(k));
      w_cap_vec[k] = req_in[k] && (!r_busy[k] || w_gnt_vec[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_ovf  <= '0;
      for (int k = 0; k < nSRC; k++)
        r_slot[k] <= '0;
    end else begin
      for (int k = 0; k < nSRC; k++) begin
        if (w_cap_vec[k]) begin
          r_busy[k] <= 1'b1;
          r_slot[k] <= data_in[k*wD +: wD];
        end else if (w_gnt_vec[k]) begin
          r_busy[k] <= 1'b0;
        end
        // A refused pulse is an overrun; the clear wins over a same-cycle set.
        if (ovf_clr)
          r_ovf[k] <= 1'b0;
        else if (req_in[k] && !w_cap_vec[k])
          r_ovf[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_slot[w_gnt_idx];
        r_out_addr  <= w_gnt_idx;
        r_rr_ptr    <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign src_busy  = r_busy;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

endmodule

`default_nettype wire

// File: tb/tb_comm_gather.sv
// ============================================================================
// Module   : tb_comm_gather
// Purpose  : Scoreboard bench for comm_gather: directed pulses, expected words
//            queued at drive time and compared as the DUT transfers them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comm_gather;

  localparam int nSRC = 13;
  localparam int wD   = 25;
  localparam int wA   = $clog2(nSRC);

  logic               clk = 1'b0;
  logic               reset;
  logic [nSRC-1:0]    req_in;
  logic [nSRC*wD-1:0] data_in;
  logic [nSRC-1:0]    src_busy;
  logic               out_valid;
  logic               out_ready;
  logic [wD-1:0]      out_data;
  logic [wA-1:0]      out_addr;
  logic [nSRC-1:0]    ovf;
  logic               ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [wA+wD-1:0] sb [$];
  logic [wA+wD-1:0] r_exp;

  comm_gather #(.nSRC(nSRC), .wD(wD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
    .src_busy  (src_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int k, input logic [wD-1:0] d, input bit expect_out);
    req_in[k] = 1'b1;
    data_in[k*wD +: wD] = d;
    if (expect_out)
      sb.push_back({wA'(k), d});
  endtask

  task automatic clear_req();
    req_in  = '0;
    data_in = '1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  // Transfer happens at the next rising edge; compare against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        r_exp = sb.pop_front();
        chk("out_addr", 64'(out_addr), 64'(r_exp[wA+wD-1:wD]));
        chk("out_data", 64'(out_data), 64'(r_exp[wD-1:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; req_in = '0; data_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_addr",  64'(out_addr),  64'd0);
    chk("rst_busy",  64'(src_busy),  64'd0);
    chk("rst_ovf",   64'(ovf),       64'd0);

    // Single pulse: two-edge latency, busy for one cycle
    out_ready = 1'b1;
    drive_src(5, 25'h0ABCDEF, 1'b1);
    step(); clear_req();
    chk("t1_busy_set", 64'(src_busy), 64'(13'h1 << 5));
    chk("t1_valid_lo", 64'(out_valid), 64'd0);
    step();
    chk("t1_busy_clr", 64'(src_busy), 64'd0);
    chk("t1_valid_hi", 64'(out_valid), 64'd1);
    step();
    chk("t1_valid_one", 64'(out_valid), 64'd0);
    wait_drain();

    // Round robin from a fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < nSRC; k++)
      drive_src(k, 25'(32'h100 + k), 1'b1);
    step(); clear_req();
    chk("t2_all_busy", 64'(src_busy), 64'(13'h1FFF));
    wait_drain();
    drive_src(11, 25'h0B0B0B, 1'b0);
    drive_src(3,  25'h030303, 1'b0);
    sb.push_back({wA'(3),  25'h030303});
    sb.push_back({wA'(11), 25'h0B0B0B});
    step(); clear_req();
    wait_drain();

    // Backpressure holds the output word stable
    out_ready = 1'b0;
    drive_src(2, 25'h1222222, 1'b1);
    drive_src(7, 25'h0777777, 1'b1);
    step(); clear_req();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", 64'(out_valid), 64'd1);
      chk("t3_addr",  64'(out_addr),  64'd2);
      chk("t3_data",  64'(out_data),  64'h1222222);
      step();
    end
    chk("t3_busy7", 64'(src_busy), 64'(13'h1 << 7));
    out_ready = 1'b1;
    wait_drain();

    // Overrun on a busy, ungranted slot
    out_ready = 1'b0;
    drive_src(1, 25'h0111111, 1'b1);
    step(); clear_req();
    step();
    drive_src(4, 25'h0AAAAAA, 1'b1);
    step(); clear_req();
    chk("t4_no_ovf_yet", 64'(ovf), 64'd0);
    drive_src(4, 25'h0BBBBBB, 1'b0);
    step(); clear_req();
    chk("t4_ovf_set", 64'(ovf), 64'(13'h1 << 4));
    chk("t4_busy", 64'(src_busy), 64'(13'h1 << 4));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 64'(ovf), 64'd0);
    ovf_clr = 1'b1;
    drive_src(4, 25'h0CCCCCC, 1'b0);
    step(); clear_req();
    ovf_clr = 1'b0;
    chk("t4_clr_prio", 64'(ovf), 64'd0);
    chk("t4_hold_addr", 64'(out_addr), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // Refill on the cycle the slot is granted
    out_ready = 1'b0;
    drive_src(0, 25'h0000AAA, 1'b1);
    step(); clear_req();
    step();
    drive_src(9, 25'h0999001, 1'b1);
    step(); clear_req();
    out_ready = 1'b1;
    drive_src(9, 25'h0999002, 1'b1);
    step(); clear_req();
    chk("t5_no_ovf", 64'(ovf), 64'd0);
    chk("t5_refilled", 64'(src_busy), 64'(13'h1 << 9));
    wait_drain();

    // Reset in the middle of a stream discards everything
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++)
      drive_src(k, 25'(32'h5000 + k), 1'b0);
    step(); clear_req();
    step();
    drive_src(3, 25'h0033333, 1'b0);
    step(); clear_req();
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_busy", 64'(src_busy), 64'(13'h0FC));
    chk("t6_pre_ovf", 64'(ovf), 64'(13'h1 << 3));
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_busy",  64'(src_busy),  64'd0);
    chk("t6_ovf",   64'(ovf),       64'd0);
    out_ready = 1'b1;
    drive_src(1,  25'h0010001, 1'b1);
    drive_src(12, 25'h0120012, 1'b1);
    step(); clear_req();
    step();
    chk("t6_first_addr", 64'(out_addr), 64'd1);
    wait_drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
